pc_unit: RTL

- Parametrised next-generation program-counter block for the MIPS multi-cycle core.
- Holds the PC and selects the next PC from these sources: sequential, branch, jump, jump-register, exception vector and ERET.
- Captures the EPC on exceptions and traps misaligned targets.
- Keeps a small return-address stack (RAS) that the fetch/control FSM uses for return prediction.
- Sits between the control FSM and instruction memory, and replaces the plain PC register.

---
 rtl/pc_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program counter for the multi-cycle core: next-PC select, EPC capture,
// misaligned-target trap and a small circular return-address stack.
module pc_unit #(
  parameter int          BIT_WIDTH    = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int          RAS_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pc_en,
  input  logic                 branch_taken,
  input  logic [BIT_WIDTH-1:0] branch_offset,
  input  logic                 jump,
  input  logic [25:0]          jump_target,
  input  logic                 jump_reg,
  input  logic [BIT_WIDTH-1:0] reg_target,
  input  logic                 link,
  input  logic                 ret,
  input  logic                 exc_req,
  input  logic                 eret,
  output logic [BIT_WIDTH-1:0] pc_out,
  output logic [BIT_WIDTH-1:0] pc_plus4,
  output logic [BIT_WIDTH-1:0] epc,
  output logic                 misaligned,
  output logic [BIT_WIDTH-1:0] ras_top,
  output logic                 ras_valid,
  output logic                 ras_overflow
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [BIT_WIDTH-1:0] RST_PC = BIT_WIDTH'(RESET_VECTOR);
  localparam logic [BIT_WIDTH-1:0] EXC_PC = BIT_WIDTH'(EXC_VECTOR);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [BIT_WIDTH-1:0] br_tgt;
  logic [BIT_WIDTH-1:0] j_tgt;
  logic [BIT_WIDTH-1:0] tgt;
  logic                 trap;
  logic                 upd;
  logic                 push;
  logic                 pop;

  logic [BIT_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]        sp;
  logic [PW-1:0]        sp_inc;
  logic [PW-1:0]        sp_dec;
  logic [CW-1:0]        cnt;

  assign pc_plus4 = pc_out + BIT_WIDTH'(4);
  assign br_tgt   = pc_plus4 + (branch_offset << 2);
  assign j_tgt    = {pc_plus4[BIT_WIDTH-1:28], jump_target, 2'b00};

  always_comb begin
    tgt = pc_plus4;
    priority case (1'b1)
      eret:         tgt = epc;
      jump_reg:     tgt = reg_target;
      jump:         tgt = j_tgt;
      branch_taken: tgt = br_tgt;
      default:      tgt = pc_plus4;
    endcase
  end

  assign trap = pc_en & ~exc_req & (|tgt[1:0]);
  assign upd  = pc_en & ~exc_req & ~trap;
  assign push = upd & link & (jump | jump_reg);
  // an empty pop is dropped so a same-cycle push acts as a plain push
  assign pop  = upd & ret & jump_reg & (cnt != '0);

  assign sp_inc = sp + 1'b1;
  assign sp_dec = sp - 1'b1;

  assign ras_valid = (cnt != '0);
  assign ras_top   = ras_valid ? ras_mem[sp] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out     <= RST_PC;
      epc        <= '0;
      misaligned <= 1'b0;
    end else begin
      misaligned <= trap;
      if (exc_req || trap) begin
        pc_out <= EXC_PC;
        epc    <= pc_out;
      end else if (pc_en) begin
        pc_out <= tgt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp           <= '0;
      cnt          <= '0;
      ras_overflow <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++)
        ras_mem[i] <= '0;
    end else begin
      ras_overflow <= 1'b0;
      if (push && pop) begin
        ras_mem[sp] <= pc_plus4;
      end else if (push) begin
        sp              <= sp_inc;
        ras_mem[sp_inc] <= pc_plus4;
        if (cnt == FULL)
          ras_overflow <= 1'b1;
        else
          cnt <= cnt + 1'b1;
      end else if (pop) begin
        sp  <= sp_dec;
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule
